paint_compositor: RTL and testbench
===================================

Name: paint_compositor

Overview:
- Final stage of the paint pipeline, directly downstream of the sprite/background layer stages.
- Takes the same scan coordinates and new_frame pulse that feed the layers and delays them to align with the layers' paint_enable/paint_color outputs.
- Selects the winning layer by fixed priority, or the background colour if no layer is enabled.
- Emits one registered framebuffer write per on-screen pixel and reports frame completion and pixel-count errors.

Parameters:
- NUM_LAYERS, 4: number of layer inputs. Index 0 has lowest priority, NUM_LAYERS-1 highest.
- LATENCY, 4: cycles from paint_x/paint_y/new_frame to the matching layer outputs. Legal range 1..8.
- SCREEN_W, 480: visible width in pixels.
- SCREEN_H, 640: visible height in pixels.
- ADDR_W, 19: framebuffer address width. Must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
- BG_COLOR, 16'h0000: colour written when no layer is enabled.
- KEY_COLOR, 16'hF81F: transparent colour, used only with the optional feature.

Ports:
- clk, input, 1: pipeline clock.
- rst, input, 1: asynchronous reset, active-high.
- new_frame, input, 1: frame-start pulse, coincident with the first coordinate of a frame.
- paint_x, input, 16: signed scan x.
- paint_y, input, 16: signed scan y.
- layer_enable, input, NUM_LAYERS: bit i is paint_enable of layer i.
- layer_color, input, 16*NUM_LAYERS: bits [16i+15:16i] are paint_color of layer i.
- fb_we, output, 1: framebuffer write strobe.
- fb_addr, output, ADDR_W: write address, y*SCREEN_W+x.
- fb_data, output, 16: RGB565 write data.
- frame_done, output, 1: one-cycle pulse with the write of pixel (SCREEN_W-1, SCREEN_H-1).
- frame_err, output, 1: sticky; set if a frame ends with a write count other than SCREEN_W*SCREEN_H.

Behaviour:
- Reset is asynchronous. On reset:
  - All delay-line stages clear to 0, including delayed new_frame and the valid bits.
  - fb_we, fb_addr, fb_data, frame_done, frame_err = 0.
  - FSM enters WAIT.
  - Write counter = 0.
- Delay line: paint_x, paint_y and new_frame are shifted through LATENCY registers. Stage LATENCY (dx, dy, dnf) is sampled in the same cycle as layer_enable/layer_color.
- Visibility: vis = dx>=0 && dx<SCREEN_W && dy>=0 && dy<SCREEN_H, compared signed.
- Pixel select: highest index i with layer_enable[i]=1 supplies the colour; otherwise BG_COLOR.
- Output register, one cycle after alignment:
  - fb_we <= vis && state==DRAW.
  - fb_addr <= dy*SCREEN_W+dx, truncated to ADDR_W. Only meaningful when fb_we=1.
  - fb_data <= selected colour.
  - Total latency from coordinate input to fb_we is LATENCY+1 cycles.
- FSM:
  - WAIT: no writes issued. On dnf=1, go to DRAW and clear the counter.
  - DRAW: counter increments on each fb_we. When a write targets (SCREEN_W-1, SCREEN_H-1), frame_done pulses with that write and the FSM goes to WAIT. If dnf=1 arrives while in DRAW (frame aborted), set frame_err, clear the counter, stay in DRAW.
  - End check: at the frame_done write, if counter+1 != SCREEN_W*SCREEN_H, set frame_err.
- Boundaries:
  - The first frame after reset is never written until its new_frame has propagated.
  - A dnf coincident with a visible pixel: the new frame starts and that pixel is written as count 1.
  - Off-screen coordinates, including negative ones, produce no write and do not count.
  - frame_err clears only on reset.
  - Reset mid-frame drops all in-flight pixels; no write is issued after rst deasserts until the next new_frame propagates.

Optional Feature:
- Macro PAINT_COMPOSITOR_COLORKEY_EN.
- When defined: a layer whose layer_enable bit is 1 but whose colour equals KEY_COLOR is treated as disabled, so the next-lower layer or BG_COLOR shows through.
- When undefined: KEY_COLOR is ignored and an enabled layer always wins.

Test Plan:
- Reset then scan one full frame, no layers enabled. Expect:
  - 307200 writes, all fb_data=0x0000.
  - First write fb_addr=0 exactly 5 cycles after new_frame.
  - frame_done with fb_addr=307199.
  - frame_err=0.
- Priority: at (10,20), layers 0 and 2 enabled with colours 0x001F and 0x07E0. Expect fb_addr=9610, fb_data=0x07E0.
- Off-screen: scan x=-4..483 on row 0. Expect writes only for x=0..479, and none for negatives or x>=480.
- Abort: second new_frame issued after 1000 pixels. Expect frame_err=1, and the counter restarts so the next full frame gives frame_done with frame_err staying 1.
- Async reset asserted mid-row, then released. Expect fb_we=0 immediately and no writes until LATENCY+1 cycles after the next new_frame.
- With PAINT_COMPOSITOR_COLORKEY_EN: layer 3 colour 0xF81F over layer 1 colour 0x1234. Expect fb_data=0x1234. Without the macro, expect fb_data=0xF81F.

Source files
------------

// File: rtl/paint_compositor.sv
// Final paint stage: aligns scan coordinates with the layer outputs, picks a colour by priority and writes the framebuffer.
// Optional colour keying is enabled by defining PAINT_COMPOSITOR_COLORKEY_EN.
module paint_compositor_lane #(
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic        en,
  input  logic [15:0] color,
  output logic        hit
);
`ifdef PAINT_COMPOSITOR_COLORKEY_EN
  assign hit = en && (color != KEY_COLOR);
`else
  logic unused_key;
  assign hit        = en;
  assign unused_key = ^{KEY_COLOR, color};
`endif
endmodule

module paint_compositor #(
  parameter int          NUM_LAYERS = 4,
  parameter int          LATENCY    = 4,
  parameter int          SCREEN_W   = 480,
  parameter int          SCREEN_H   = 640,
  parameter int          ADDR_W     = 19,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [15:0] KEY_COLOR  = 16'hF81F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_frame,
  input  logic [15:0]              paint_x,
  input  logic [15:0]              paint_y,
  input  logic [NUM_LAYERS-1:0]    layer_enable,
  input  logic [16*NUM_LAYERS-1:0] layer_color,
  output logic                     fb_we,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [15:0]              fb_data,
  output logic                     frame_done,
  output logic                     frame_err
);
  localparam int TOTAL = SCREEN_W * SCREEN_H;

  typedef enum logic {ST_WAIT, ST_DRAW} state_t;
  state_t state, state_n;

  logic [LATENCY-1:0][15:0] x_pipe, y_pipe;
  logic [LATENCY-1:0]       nf_pipe;
  logic [LATENCY:1]         vld_pipe;
  logic [ADDR_W:0]          cnt, cnt_base, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pipe   <= '0;
      y_pipe   <= '0;
      nf_pipe  <= '0;
      vld_pipe <= '0;
    end else begin
      x_pipe[0]   <= paint_x;
      y_pipe[0]   <= paint_y;
      nf_pipe[0]  <= new_frame;
      vld_pipe[1] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        x_pipe[i]     <= x_pipe[i-1];
        y_pipe[i]     <= y_pipe[i-1];
        nf_pipe[i]    <= nf_pipe[i-1];
        vld_pipe[i+1] <= vld_pipe[i];
      end
    end
  end

  logic signed [15:0] dx, dy;
  logic               dnf, vis;
  assign dx  = x_pipe[LATENCY-1];
  assign dy  = y_pipe[LATENCY-1];
  assign dnf = nf_pipe[LATENCY-1] && vld_pipe[LATENCY];
  assign vis = vld_pipe[LATENCY] && (dx >= 0) && (int'(dx) < SCREEN_W) &&
               (dy >= 0) && (int'(dy) < SCREEN_H);

  logic [NUM_LAYERS-1:0] hit;
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    paint_compositor_lane #(.KEY_COLOR(KEY_COLOR)) u_lane (
      .en    (layer_enable[g]),
      .color (layer_color[16*g +: 16]),
      .hit   (hit[g])
    );
  end

  // Ascending scan lets the highest-index enabled layer overwrite lower ones.
  logic [15:0] sel_color;
  always_comb begin
    sel_color = BG_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (hit[i]) sel_color = layer_color[16*i +: 16];
  end

  logic [ADDR_W-1:0] pix_addr;
  assign pix_addr = ADDR_W'(32'($unsigned(dy)) * 32'(SCREEN_W) + 32'($unsigned(dx)));

  // A frame-start pixel is drawn even while still in WAIT: it becomes count 1.
  logic wr, last, err_n;
  always_comb begin
    state_n  = state;
    cnt_base = dnf ? '0 : cnt;
    wr       = vis && (state == ST_DRAW || dnf);
    last     = wr && (int'(dx) == SCREEN_W - 1) && (int'(dy) == SCREEN_H - 1);
    cnt_n    = cnt_base + {{ADDR_W{1'b0}}, wr};
    err_n    = frame_err;
    if (dnf) begin
      state_n = ST_DRAW;
      if (state == ST_DRAW) err_n = 1'b1;
    end
    if (last) begin
      state_n = ST_WAIT;
      if ((32'(cnt_base) + 32'd1) != 32'(TOTAL)) err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT;
      cnt        <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fb_we      <= wr;
      fb_addr    <= pix_addr;
      fb_data    <= sel_color;
      frame_done <= last;
      frame_err  <= err_n;
    end
  end
endmodule

// File: tb/tb_paint_compositor.sv
// Randomized bench for paint_compositor with a pixel-level reference model (short 480x24 screen).
module tb_paint_compositor;
  localparam int LAT = 4, W = 480, H = 24, AW = 19, N = 4;
  localparam logic [15:0] KEY = 16'hF81F;

  logic clk = 0, rst = 1, new_frame = 0;
  logic [15:0] paint_x = 0, paint_y = 0;
  logic [N-1:0] layer_enable = 0;
  logic [16*N-1:0] layer_color = 0;
  logic fb_we, frame_done, frame_err;
  logic [AW-1:0] fb_addr;
  logic [15:0] fb_data;

  always #5 clk = ~clk;

  paint_compositor #(.NUM_LAYERS(N), .LATENCY(LAT), .SCREEN_W(W), .SCREEN_H(H),
                     .ADDR_W(AW), .BG_COLOR(16'h0000), .KEY_COLOR(KEY)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .paint_x(paint_x), .paint_y(paint_y),
    .layer_enable(layer_enable), .layer_color(layer_color), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done), .frame_err(frame_err));

  typedef struct { logic nf; int x; int y; logic [3:0] en; logic [63:0] col; } pix_t;
  pix_t hist[$];

  int n_chk = 0, n_err = 0, step_n = 0;
  bit m_draw; int m_cnt; bit m_err;
  int wr_count, first_wr, first_addr, done_addr, cap_addr, nf_step;
  logic [15:0] cap_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_n);
    end
  endtask

  // Frame-level reference: what the framebuffer should see for one aligned pixel.
  task automatic ref_model(input pix_t a, output bit we, output int addr,
                           output logic [15:0] data, output bit done);
    bit vis;
    vis  = a.x >= 0 && a.x < W && a.y >= 0 && a.y < H;
    data = 16'h0000;
    for (int i = 0; i < N; i++) begin
      logic [15:0] c;
      c = a.col[16*i +: 16];
`ifdef PAINT_COMPOSITOR_COLORKEY_EN
      if (a.en[i] && c != KEY) data = c;
`else
      if (a.en[i]) data = c;
`endif
    end
    if (a.nf) begin
      if (m_draw) m_err = 1;
      m_draw = 1;
      m_cnt  = 0;
    end
    we   = m_draw && vis;
    addr = a.y * W + a.x;
    done = 0;
    if (we) begin
      m_cnt++;
      if (a.x == W - 1 && a.y == H - 1) begin
        done   = 1;
        m_draw = 0;
        if (m_cnt != W * H) m_err = 1;
      end
    end
  endtask

  task automatic step(input logic nf, input int x, input int y, input logic [3:0] en,
                      input logic [63:0] col);
    pix_t a; bit e_we, e_done; int e_addr; logic [15:0] e_data;
    hist.push_back('{nf: nf, x: x, y: y, en: en, col: col});
    a = hist.pop_front();
    new_frame = nf; paint_x = 16'(x); paint_y = 16'(y);
    layer_enable = a.en; layer_color = a.col;
    ref_model(a, e_we, e_addr, e_data, e_done);
    @(posedge clk); #1;
    check("fb_we", 32'(fb_we), 32'(e_we));
    if (e_we) check("fb_addr", 32'(fb_addr), 32'(e_addr));
    check("fb_data", 32'(fb_data), 32'(e_data));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("frame_err", 32'(frame_err), 32'(m_err));
    if (fb_we) begin
      wr_count++;
      if (first_wr < 0) begin first_wr = step_n; first_addr = 32'(fb_addr); end
      if (32'(fb_addr) == cap_addr) cap_data = fb_data;
    end
    if (frame_done) done_addr = 32'(fb_addr);
    step_n++;
  endtask

  task automatic rnd_layers(output logic [3:0] en, output logic [63:0] col);
    en  = 4'($urandom);
    col = {$urandom, $urandom};
    for (int i = 0; i < N; i++)
      if ($urandom_range(7) == 0) col[16*i +: 16] = KEY;
  endtask

  task automatic scan(input int npix, input bit rnd, input bit oob);
    logic [3:0] en; logic [63:0] col;
    for (int k = 0; k < npix; k++) begin
      int x, y;
      x = k % W; y = k / W;
      en = 0; col = 0;
      if (oob && y == 0 && x == 0)
        for (int i = -4; i < 0; i++) begin rnd_layers(en, col); step(0, i, 0, en, col); end
      if (rnd && k > 0 && $urandom_range(63) == 0) begin
        rnd_layers(en, col);
        step(0, $urandom_range(1) ? -1 - int'($urandom_range(200)) : x, -1 - int'($urandom_range(5)), en, col);
      end
      if (rnd) rnd_layers(en, col);
      if (x == 10 && y == 20) begin en = 4'b0101; col = 64'h0000_07E0_0000_001F; end
      step(k == 0, x, y, en, col);
      if (oob && y == 0 && x == W - 1)
        for (int i = W; i < W + 4; i++) begin rnd_layers(en, col); step(0, i, 0, en, col); end
    end
  endtask

  task automatic flush();
    repeat (LAT + 1) step(0, -1, -1, 4'b0, 64'b0);
  endtask

  task automatic clear_stats();
    wr_count = 0; first_wr = -1; first_addr = -1; done_addr = -1;
    cap_addr = -1; cap_data = 16'hDEAD; nf_step = step_n;
  endtask

  task automatic do_reset();
    #2 rst = 1; new_frame = 0;
    #1;
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_data", 32'(fb_data), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_err), 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    hist.delete();
    repeat (LAT) hist.push_back('{nf: 0, x: 0, y: 0, en: 4'b0, col: 64'b0});
    m_draw = 0; m_cnt = 0; m_err = 0;
  endtask

  initial begin
    logic [3:0] en; logic [63:0] col;
    do_reset();

    // Blank frame: background only, latency and end-of-frame address.
    clear_stats();
    scan(W * H, 0, 0);
    flush();
    check("first_lat", 32'(first_wr - nf_step), LAT);
    check("first_addr", 32'(first_addr), 0);
    check("done_addr", 32'(done_addr), W * H - 1);
    check("wr_count", 32'(wr_count), W * H);
    check("err_clean", 32'(frame_err), 0);

    // Random layers, off-screen pixels on row 0 and scattered, priority pixel.
    clear_stats();
    cap_addr = 20 * W + 10;
    scan(W * H, 1, 1);
    flush();
    check("prio", 32'(cap_data), 32'h07E0);
    check("wr_count_oob", 32'(wr_count), W * H);
    check("err_clean2", 32'(frame_err), 0);

    // Aborted frame followed by a complete one.
    clear_stats();
    scan(1000, 1, 0);
    scan(W * H, 1, 0);
    flush();
    check("abort_err", 32'(frame_err), 1);
    check("abort_done", 32'(done_addr), W * H - 1);

    // Reset mid-row, then no writes until the next frame start propagates.
    scan(300, 1, 0);
    do_reset();
    clear_stats();
    for (int i = 0; i < 30; i++) begin rnd_layers(en, col); step(0, i, 1, en, col); end
    check("no_wr_after_rst", 32'(wr_count), 0);
    clear_stats();
    scan(100, 1, 0);
    flush();
    check("rst_lat", 32'(first_wr - nf_step), LAT);
    check("rst_wr_count", 32'(wr_count), 100);

    // Key colour on layer 3 over layer 1.
    clear_stats();
    cap_addr = 5 * W + 5;
    step(1, 5, 5, 4'b1010, 64'hF81F_0000_1234_0000);
    flush();
`ifdef PAINT_COMPOSITOR_COLORKEY_EN
    check("colorkey", 32'(cap_data), 32'h1234);
`else
    check("colorkey", 32'(cap_data), 32'hF81F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
